// File: rtl/hs32_sram_ctl.sv
// hs32_sram_ctl: banked single-port SRAM controller shared by the HS32 core
// data port and the management Wishbone slave. It arbitrates round-robin,
// decodes bank/row in linear or interleaved mode, drives the macro pins
// combinationally in the grant cycle and acks one cycle later.
module hs32_sram_ctl #(
  parameter int          NBANKS     = 4,
  parameter int          AW         = 8,
  parameter int          INTERLEAVE = 0,
  parameter logic [31:0] WB_BASE    = 32'h0003_0000,
  localparam int         BW         = $clog2(NBANKS),
  localparam int         XW         = AW + BW + 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [3:0]            cpu_sel_i,
  input  logic [XW-1:0]         cpu_addr_i,
  input  logic [31:0]           cpu_dtw_i,
  output logic [31:0]           cpu_dtr_o,
  output logic                  cpu_ack_o,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [NBANKS-1:0]     sram_csb_o,
  output logic                  sram_web_o,
  output logic [3:0]            sram_wmask_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [31:0]           sram_din_o,
  input  logic [32*NBANKS-1:0]  sram_dout_i
);

  // Bank index is at least one bit wide so a single-bank build still elaborates.
  localparam int BI = (BW > 0) ? BW : 1;
  localparam int WW = AW + BW;
  localparam int UW = 32 - XW;

  typedef enum logic {IDLE, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [3:0]    sel;
    logic [BI-1:0] bank;
    logic [AW-1:0] row;
    logic [31:0]   dat;
  } req_t;

  // Split the word index into bank and row according to the bank-select mode.
  function automatic req_t mk_req(input logic [WW-1:0] w, input logic we,
                                  input logic [3:0] sel, input logic [31:0] dat);
    req_t r;
    r.we  = we;
    r.sel = sel;
    r.dat = dat;
    if (INTERLEAVE != 0) begin
      r.bank = BI'(w & WW'(NBANKS - 1));
      r.row  = AW'(w >> BW);
    end else begin
      r.bank = BI'(w >> AW);
      r.row  = AW'(w);
    end
    return r;
  endfunction

  state_t        state;
  logic          last_wb;   // last grant went to Wishbone
  logic [BI-1:0] bank_q;
  logic          wb_hit, grant_cpu, grant_wb, go;
  req_t          cpu_r, wb_r, req;
  logic [31:0]   rd;
  logic          unused_addr;

  assign unused_addr = ^{cpu_addr_i[1:0], wbs_adr_i[1:0]};

  assign cpu_r = mk_req(cpu_addr_i[XW-1:2], cpu_we_i, cpu_sel_i, cpu_dtw_i);
  assign wb_r  = mk_req(wbs_adr_i[XW-1:2], wbs_we_i, wbs_sel_i, wbs_dat_i);

  // Foreign Wishbone addresses are invisible to the arbiter.
  assign wb_hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:XW] == WB_BASE[UW-1:0]);
  // On a tie the side that did not win last time gets the grant.
  assign grant_cpu = cpu_req_i & (~wb_hit | last_wb);
  assign grant_wb  = wb_hit & ~grant_cpu;
  // Reset gates the grant so the pins sit idle while reset is held.
  assign go        = wb_rst_ni & (state == IDLE) & (cpu_req_i | wb_hit);
  assign req       = grant_cpu ? cpu_r : wb_r;

  // Macro pins: idle values unless a grant is issued this cycle.
  always_comb begin
    sram_csb_o   = '1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (go) begin
      for (int k = 0; k < NBANKS; k++)
        if (req.bank == BI'(k)) sram_csb_o[k] = 1'b0;
      sram_web_o   = ~req.we;
      sram_wmask_o = req.sel;
      sram_addr_o  = req.row;
      sram_din_o   = req.dat;
    end
  end

  // Return-data mux on the bank captured at grant time.
  always_comb begin
    rd = '0;
    for (int k = 0; k < NBANKS; k++)
      if (bank_q == BI'(k)) rd = sram_dout_i[32*k +: 32];
  end

  assign cpu_dtr_o = cpu_ack_o ? rd : 32'h0;
  assign wbs_dat_o = wbs_ack_o ? rd : 32'h0;

  // Two-state FSM: grant in IDLE, registered ack in RESP.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      last_wb   <= 1'b1;
      bank_q    <= '0;
      cpu_ack_o <= 1'b0;
      wbs_ack_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state     <= RESP;
            last_wb   <= grant_wb;
            bank_q    <= req.bank;
            cpu_ack_o <= grant_cpu;
            wbs_ack_o <= grant_wb;
          end
        end
        RESP: begin
          state     <= IDLE;
          cpu_ack_o <= 1'b0;
          wbs_ack_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_sram_ctl.sv
// Directed bench for hs32_sram_ctl: one linear (index 0) and one interleaved
// (index 1) instance share all requester inputs, each with its own SRAM model.
module tb_hs32_sram_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [3:0]  cpu_sel;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_dtw;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat;

  logic [1:0][31:0]  cpu_dtr, wbs_dat, din;
  logic [1:0]        cpu_ack, wbs_ack, web;
  logic [1:0][3:0]   csb, wmask;
  logic [1:0][7:0]   addr;
  logic [1:0][127:0] dout;

  logic [31:0] mem [2][4][256];

  int n_asrt = 0;
  int n_fail = 0;

  hs32_sram_ctl #(.NBANKS(4), .AW(8), .INTERLEAVE(0)) u_lin (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel),
    .cpu_addr_i(cpu_addr), .cpu_dtw_i(cpu_dtw),
    .cpu_dtr_o(cpu_dtr[0]), .cpu_ack_o(cpu_ack[0]),
    .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_we_i(wb_we),
    .wbs_sel_i(wb_sel), .wbs_adr_i(wb_adr), .wbs_dat_i(wb_dat),
    .wbs_ack_o(wbs_ack[0]), .wbs_dat_o(wbs_dat[0]),
    .sram_csb_o(csb[0]), .sram_web_o(web[0]), .sram_wmask_o(wmask[0]),
    .sram_addr_o(addr[0]), .sram_din_o(din[0]), .sram_dout_i(dout[0]));

  hs32_sram_ctl #(.NBANKS(4), .AW(8), .INTERLEAVE(1)) u_ilv (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel),
    .cpu_addr_i(cpu_addr), .cpu_dtw_i(cpu_dtw),
    .cpu_dtr_o(cpu_dtr[1]), .cpu_ack_o(cpu_ack[1]),
    .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_we_i(wb_we),
    .wbs_sel_i(wb_sel), .wbs_adr_i(wb_adr), .wbs_dat_i(wb_dat),
    .wbs_ack_o(wbs_ack[1]), .wbs_dat_o(wbs_dat[1]),
    .sram_csb_o(csb[1]), .sram_web_o(web[1]), .sram_wmask_o(wmask[1]),
    .sram_addr_o(addr[1]), .sram_din_o(din[1]), .sram_dout_i(dout[1]));

  // Port-0 macro model: samples pins at the rising edge, read data registered.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        if (!csb[d][k]) begin
          if (!web[d]) begin
            for (int b = 0; b < 4; b++)
              if (wmask[d][b]) mem[d][k][addr[d]][8*b +: 8] <= din[d][8*b +: 8];
          end else begin
            dout[d][32*k +: 32] <= mem[d][k][addr[d]];
          end
        end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_set(input logic we, input logic [3:0] sel,
                         input logic [9:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_sel = sel; cpu_addr = a; cpu_dtw = d;
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_sel = 0; cpu_addr = 0; cpu_dtw = 0;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0; wb_adr = 0; wb_dat = 0;

    // Reset with a pending request: pins must stay idle.
    cpu_set(1'b1, 4'hF, 10'h104, 32'h1111_2222);
    tick; tick;
    chk("rst_csb0", 32'(csb[0]), 32'hF);
    chk("rst_csb1", 32'(csb[1]), 32'hF);
    chk("rst_web", 32'(web), 32'h3);
    chk("rst_wmask", 32'(wmask[0]), 32'h0);
    chk("rst_addr", 32'(addr[0]), 32'h0);
    chk("rst_din", din[0], 32'h0);
    chk("rst_acks", 32'({cpu_ack, wbs_ack}), 32'h0);
    cpu_req = 1'b0;
    rst_n = 1'b1;
    tick; tick;
    chk("idle_csb", 32'(csb), 32'hFF);
    chk("idle_acks", 32'({cpu_ack, wbs_ack}), 32'h0);

    // CPU full-word write at 0x104.
    cpu_set(1'b1, 4'hF, 10'h104, 32'hDEAD_BEEF);
    #1;
    chk("wr_csb_lin", 32'(csb[0]), 32'hE);
    chk("wr_csb_ilv", 32'(csb[1]), 32'hD);
    chk("wr_addr_lin", 32'(addr[0]), 32'h41);
    chk("wr_addr_ilv", 32'(addr[1]), 32'h10);
    chk("wr_web", 32'(web), 32'h0);
    chk("wr_wmask", 32'(wmask[0]), 32'hF);
    chk("wr_din", din[0], 32'hDEAD_BEEF);
    tick;
    chk("wr_ack", 32'(cpu_ack), 32'h3);
    chk("wr_wbs_ack", 32'(wbs_ack), 32'h0);
    chk("resp_csb", 32'(csb), 32'hFF);
    cpu_req = 1'b0;
    tick;
    chk("wr_ack_pulse", 32'(cpu_ack), 32'h0);

    // Read back.
    cpu_set(1'b0, 4'hF, 10'h104, 32'h0);
    #1;
    chk("rd_web", 32'(web), 32'h3);
    tick;
    chk("rd_ack", 32'(cpu_ack), 32'h3);
    chk("rd_dat_lin", cpu_dtr[0], 32'hDEAD_BEEF);
    chk("rd_dat_ilv", cpu_dtr[1], 32'hDEAD_BEEF);
    cpu_req = 1'b0;
    tick;
    chk("rd_dat_gated", cpu_dtr[0], 32'h0);

    // Byte write into byte 1, then read the merged word.
    cpu_set(1'b1, 4'b0010, 10'h104, 32'h0000_AB00);
    #1;
    chk("bw_wmask", 32'(wmask[1]), 32'h2);
    tick;
    chk("bw_ack", 32'(cpu_ack), 32'h3);
    cpu_req = 1'b0;
    tick;
    cpu_set(1'b0, 4'hF, 10'h104, 32'h0);
    tick;
    chk("bw_rd_ilv", cpu_dtr[1], 32'hDEAD_ABEF);
    chk("bw_rd_lin", cpu_dtr[0], 32'hDEAD_ABEF);
    cpu_req = 1'b0;
    tick;

    // Fresh reset so last-grant is WB; then a simultaneous CPU read / WB write.
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    cpu_set(1'b0, 4'hF, 10'h104, 32'h0);
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_sel = 4'hF;
    wb_adr = 32'h3000_0200; wb_dat = 32'hCAFE_F00D;
    #1;
    chk("tie1_addr", 32'(addr[0]), 32'h41);
    chk("tie1_web", 32'(web[0]), 32'h1);
    tick;
    chk("tie1_cpu_ack", 32'(cpu_ack[0]), 32'h1);
    chk("tie1_wb_ack", 32'(wbs_ack[0]), 32'h0);
    chk("tie1_cpu_dat", cpu_dtr[0], 32'hDEAD_ABEF);
    cpu_req = 1'b0;
    tick;
    chk("tie1_wb_csb", 32'(csb[0]), 32'hE);
    chk("tie1_wb_addr", 32'(addr[0]), 32'h80);
    chk("tie1_wb_addr_ilv", 32'(addr[1]), 32'h20);
    chk("tie1_wb_web", 32'(web[0]), 32'h0);
    tick;
    chk("tie1_wb_ack2", 32'(wbs_ack), 32'h3);
    chk("tie1_cpu_ack2", 32'(cpu_ack), 32'h0);
    wb_cyc = 0; wb_stb = 0;
    tick;

    // Second tie after a WB grant goes to the CPU.
    cpu_set(1'b0, 4'hF, 10'h104, 32'h0);
    wb_cyc = 1; wb_stb = 1; wb_we = 0;
    #1;
    chk("tie2_addr", 32'(addr[0]), 32'h41);
    tick;
    chk("tie2_cpu_ack", 32'(cpu_ack[0]), 32'h1);
    chk("tie2_wb_gated", wbs_dat[0], 32'h0);
    cpu_req = 1'b0;
    tick;
    chk("tie2_wb_addr", 32'(addr[0]), 32'h80);
    tick;
    chk("tie2_wb_ack", 32'(wbs_ack[0]), 32'h1);
    chk("tie2_wb_dat_lin", wbs_dat[0], 32'hCAFE_F00D);
    chk("tie2_wb_dat_ilv", wbs_dat[1], 32'hCAFE_F00D);
    wb_cyc = 0; wb_stb = 0;
    tick;

    // Foreign Wishbone address is never claimed.
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h2000_0000;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("foreign_csb", 32'(csb), 32'hFF);
      chk("foreign_ack", 32'(wbs_ack), 32'h0);
      tick;
    end
    wb_cyc = 0; wb_stb = 0;

    // Reset during RESP aborts the ack; held request is re-served after release.
    cpu_set(1'b0, 4'hF, 10'h104, 32'h0);
    tick;
    rst_n = 1'b0;
    #1;
    chk("abort_ack", 32'(cpu_ack), 32'h0);
    tick;
    chk("abort_csb", 32'(csb), 32'hFF);
    chk("abort_ack_held", 32'(cpu_ack), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("rel_ack", 32'(cpu_ack), 32'h0);
    chk("rel_csb", 32'(csb[0]), 32'hE);
    tick;
    chk("rel_ack2", 32'(cpu_ack), 32'h3);
    chk("rel_dat", cpu_dtr[0], 32'hDEAD_ABEF);
    cpu_req = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/hs32_sram_ctl.md
# hs32_sram_ctl

Parametrised banked SRAM controller for the HS32 user project. It sits between the wrapper's `sram_1rw1r_32_256_8_sky130` macros (port 0 only) and two requesters: the HS32 core data port and the management Wishbone slave. It arbitrates round-robin between the two, decodes bank and row from a byte address in linear or interleaved mode, and returns a registered handshake one cycle after the macro samples the request. It replaces the fixed per-macro slicing in the wrapper with N word-wide banks.

## Interface
Parameters:
- `NBANKS`, 4: number of 32-bit SRAM banks; power of two, 1 to 8. BW = log2(NBANKS).
- `AW`, 8: row address width per bank.
- `INTERLEAVE`, 0: bank-select mode. 0 uses the word-index high bits. 1 uses the word-index low bits.
- `WB_BASE`, 20'h30000: value that `wbs_adr_i[31:AW+BW+2]` must match for the Wishbone port to claim an access.

Ports:
- `wb_clk_i` in 1: single clock; also clocks the macros.
- `wb_rst_ni` in 1: asynchronous, active-low reset.
- `cpu_req_i` in 1: CPU request; held until `cpu_ack_o`.
- `cpu_we_i` in 1: CPU write enable.
- `cpu_sel_i` in 4: CPU byte enables.
- `cpu_addr_i` in AW+BW+2: CPU byte address; bits [1:0] ignored.
- `cpu_dtw_i` in 32: CPU write data.
- `cpu_dtr_o` out 32: CPU read data; valid while `cpu_ack_o`.
- `cpu_ack_o` out 1: one-cycle completion pulse.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic slave controls.
- `wbs_sel_i` in 4, `wbs_adr_i` in 32, `wbs_dat_i` in 32: Wishbone select, address and write data.
- `wbs_ack_o` out 1: Wishbone ack pulse.
- `wbs_dat_o` out 32: Wishbone read data.
- `sram_csb_o` out NBANKS: per-bank active-low chip select.
- `sram_web_o` out 1: active-low write enable, shared by all banks.
- `sram_wmask_o` out 4, `sram_addr_o` out AW, `sram_din_o` out 32: shared by all banks.
- `sram_dout_i` in 32*NBANKS: bank k read data on bits [32k+31:32k].

## Operation
- Word index W = addr[AW+BW+1:2].
  - INTERLEAVE=0: bank = W[AW+BW-1:AW], row = W[AW-1:0].
  - INTERLEAVE=1: bank = W[BW-1:0], row = W[AW+BW-1:BW].
- Wishbone request = `wbs_cyc_i & wbs_stb_i` and an upper-address match against `WB_BASE`. A non-matching access is never acked and never touches the SRAM.
- FSM has two states: IDLE and RESP.
  - IDLE, at least one request present: grant one requester and drive the macro pins combinationally that cycle.
    - Selected bank `sram_csb_o` bit = 0.
    - `sram_web_o` = ~we.
    - `sram_wmask_o` = sel.
    - `sram_addr_o` = row.
    - `sram_din_o` = write data.
  - At the clock edge: register the grant owner and bank index, then go to RESP.
  - RESP: assert the owner's ack for exactly one cycle. Read data = `sram_dout_i` slice of the registered bank. Writes also ack; read data is don't-care. All csb are high. Go to IDLE.
- Arbitration on a tie is round-robin: the requester not granted last wins. The last-grant register resets to WB, so the first tie goes to the CPU. A sole requester is always granted.
- Writes with sel=0 still access the macro with mask 0 (no change) and are acked.
- Idle pin values, also forced during reset: csb all 1, web 1, wmask 0, addr 0, din 0.
- The non-owner's ack stays 0. `cpu_dtr_o` and `wbs_dat_o` are 0 when their ack is low.

## Timing
- Access presented in IDLE cycle N: macro samples at the edge ending N; ack and read data are valid in cycle N+1.
- Throughput is at most one access per 2 cycles. A Wishbone master drops `stb` after ack, so IDLE at N+2 does not re-issue it.
- A CPU request still high in N+2 after an ack is a new request.
- Reset: outputs as above, state IDLE, last-grant = WB.
  - Reset asserted during RESP aborts the access: no ack is produced, even after release.
  - First possible grant is in the first cycle after release.
- Requests arriving while in RESP wait for IDLE; no request is dropped.

## Test plan
- Reset held → `sram_csb_o`=4'hF, `sram_web_o`=1, both acks 0. Release, no requests → unchanged.
- INTERLEAVE=0, CPU write 0x104 / 0xDEADBEEF / sel 4'hF → cycle N: csb=4'b1110, addr=0x41, web=0. `cpu_ack_o` in N+1. Read back → `cpu_dtr_o`=0xDEADBEEF.
- INTERLEAVE=1, same address → csb=4'b1101, addr=0x10. Byte write sel 4'b0010, data 0x0000AB00, then read → 0xDEADABEF.
- CPU and WB (adr 0x3000_0200) request in the same cycle N → CPU acks in N+1. WB is granted in N+2 (csb=4'b1110, addr=0x80) and acks in N+3. A next simultaneous tie goes to the CPU.
- WB access at 0x2000_0000 → no ack for 20 cycles; csb stays 4'hF.
- Reset pulsed in the RESP cycle of a CPU read → no `cpu_ack_o`. After release, a held request is re-served with ack 2 cycles later.
